// File: rtl/mdu_pkg.sv
// Shared constants and types for the iterative multiply/divide unit:
// opcode and FSM encodings, iteration count and the divide-by-zero quotient.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int ITER      = 32;

  localparam logic [MDU_WIDTH-1:0] DIV0_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX
  } state_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// Operand/result bundle between the register-file side of the core and the MDU.
// The master side launches operations and MTHI/MTLO writes; the slave side is the MDU.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);

  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             HiWE;
  logic             LoWE;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (
    output Start, Op, A, B, HiWE, LoWE,
    input  Busy, Done, Hi, Lo
  );

  modport slave (
    input  Start, Op, A, B, HiWE, LoWE,
    output Busy, Done, Hi, Lo
  );

endinterface

// File: rtl/mdu_div_step.sv
// One combinational restoring-division step: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits and emit the quotient bit.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The incoming remainder is always below the divisor, so a successful
  // subtraction leaves a result that fits back into WIDTH bits.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {1'b0, div_i};
    qbit_o  = ~diff[WIDTH];
    rem_o   = qbit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding HI/LO for MFHI/MFLO and MTHI/MTLO.
// Define MDU_FAST_MUL_EN to complete multiplies in a single cycle; divides stay iterative.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input logic           Clk,
  input logic           Reset,
  mul_div_unit_if.slave bus
);

  localparam int CW = $clog2(ITER);

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   aRaw_q;
  logic               isDiv_q;
  logic               negA_q;
  logic               negRes_q;
  logic               divZero_q;
  logic               busy_q;
  logic               done_q;
  logic               pend_q;
  logic [WIDTH-1:0]   resHi_q;
  logic [WIDTH-1:0]   resLo_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               isSigned;
  logic               isDiv;
  logic               aNeg;
  logic               bNeg;
  logic               canAccept;
  logic               fastHit;
  logic [WIDTH-1:0]   aMag;
  logic [WIDTH-1:0]   bMag;
  logic [WIDTH:0]     mSum;
  logic [2*WIDTH-1:0] multNext;
  logic [2*WIDTH-1:0] divNext;
  logic [2*WIDTH-1:0] prodFix;
  logic [2*WIDTH-1:0] fastProd;
  logic [WIDTH-1:0]   remNext;
  logic               qBit;

  // Accepting work also requires the result write-back of the previous
  // operation to have retired, so Busy covers the cycle after FIX.
  always_comb begin
    isSigned  = ~bus.Op[0];
    isDiv     = bus.Op[1];
    aNeg      = isSigned & bus.A[WIDTH-1];
    bNeg      = isSigned & bus.B[WIDTH-1];
    aMag      = aNeg ? -bus.A : bus.A;
    bMag      = bNeg ? -bus.B : bus.B;
    canAccept = (state_q == ST_IDLE) && !busy_q && !pend_q;
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] aExt;
  logic [2*WIDTH-1:0] bExt;

  always_comb begin
    aExt     = {{WIDTH{aNeg}}, bus.A};
    bExt     = {{WIDTH{bNeg}}, bus.B};
    fastProd = aExt * bExt;
    fastHit  = ~isDiv;
  end
`else
  always_comb begin
    fastProd = '0;
    fastHit  = 1'b0;
  end
`endif

  // Multiply: LSB of the low half is the current multiplier bit; the product
  // shifts in from the top as the multiplier shifts out at the bottom.
  always_comb begin
    mSum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    multNext = {mSum, acc_q[WIDTH-1:1]};
    divNext  = {remNext, acc_q[WIDTH-2:0], qBit};
    prodFix  = negRes_q ? -acc_q : acc_q;
  end

  mdu_div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .rem_i  (acc_q[2*WIDTH-1:WIDTH]),
    .bit_i  (acc_q[WIDTH-1]),
    .div_i  (opnd_q),
    .rem_o  (remNext),
    .qbit_o (qBit)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      aRaw_q    <= '0;
      isDiv_q   <= 1'b0;
      negA_q    <= 1'b0;
      negRes_q  <= 1'b0;
      divZero_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pend_q    <= 1'b0;
      resHi_q   <= '0;
      resLo_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      busy_q <= (state_q != ST_IDLE);
      done_q <= 1'b0;
      pend_q <= 1'b0;

      if (pend_q) begin
        hi_q   <= resHi_q;
        lo_q   <= resLo_q;
        done_q <= 1'b1;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (canAccept && bus.Start) begin
            if (fastHit) begin
              {resHi_q, resLo_q} <= fastProd;
              pend_q             <= 1'b1;
            end else begin
              state_q   <= ST_RUN;
              cnt_q     <= '0;
              isDiv_q   <= isDiv;
              negA_q    <= aNeg;
              negRes_q  <= aNeg ^ bNeg;
              divZero_q <= (bus.B == '0);
              aRaw_q    <= bus.A;
              opnd_q    <= isDiv ? bMag : aMag;
              acc_q     <= {{WIDTH{1'b0}}, (isDiv ? aMag : bMag)};
            end
          end else if (canAccept) begin
            if (bus.HiWE) hi_q <= bus.A;
            if (bus.LoWE) lo_q <= bus.A;
          end
        end

        ST_RUN: begin
          acc_q <= isDiv_q ? divNext : multNext;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(ITER - 1)) state_q <= ST_FIX;
        end

        ST_FIX: begin
          if (!isDiv_q) begin
            {resHi_q, resLo_q} <= prodFix;
          end else if (divZero_q) begin
            resHi_q <= aRaw_q;
            resLo_q <= WIDTH'(DIV0_QUOT);
          end else begin
            resHi_q <= negA_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            resLo_q <= negRes_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          end
          pend_q  <= 1'b1;
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.Busy = busy_q;
  assign bus.Done = done_q;
  assign bus.Hi   = hi_q;
  assign bus.Lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: hand-computed MULT/DIV results, latency,
// divide-by-zero, overflow divide, ignored requests while busy, and mid-run reset.
module tb_mul_div_unit;
  import mdu_pkg::*;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT  = 1;
  localparam int MUL_BUSY = 0;
`else
  localparam int MUL_LAT  = 34;
  localparam int MUL_BUSY = 33;
`endif
  localparam int DIV_LAT  = 34;
  localparam int DIV_BUSY = 33;

  logic Clk;
  logic Reset;
  int   testCnt;
  int   failCnt;
  int   lat;
  int   busyCnt;
  int   doneCnt;

  mul_div_unit_if #(.WIDTH(32)) bus ();

  mul_div_unit dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCnt++;
    assert (obs === exp)
    else begin
      failCnt++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request cycle; returns #1 after the edge that sampled it.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic hiWe, input logic loWe, input logic start);
    @(negedge Clk);
    bus.Start = start;
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
    bus.HiWE  = hiWe;
    bus.LoWE  = loWe;
    @(posedge Clk);
    #1;
    bus.Start = 1'b0;
    bus.HiWE  = 1'b0;
    bus.LoWE  = 1'b0;
  endtask

  task automatic waitDone(output int latOut, output int busyOut);
    latOut  = 0;
    busyOut = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge Clk);
      #1;
      latOut++;
      if (bus.Busy) busyOut++;
      if (bus.Done) break;
    end
  endtask

  task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo,
                       input int expLat, input int expBusy);
    int l;
    int bc;
    applyStimulus(op, a, b, 1'b0, 1'b0, 1'b1);
    waitDone(l, bc);
    checkOutput({tag, "_hi"}, 64'(bus.Hi), 64'(expHi));
    checkOutput({tag, "_lo"}, 64'(bus.Lo), 64'(expLo));
    checkOutput({tag, "_lat"}, 64'(l), 64'(expLat));
    checkOutput({tag, "_busy"}, 64'(bc), 64'(expBusy));
  endtask

  initial begin
    testCnt   = 0;
    failCnt   = 0;
    Reset     = 1'b1;
    bus.Start = 1'b0;
    bus.Op    = OP_MULT;
    bus.A     = '0;
    bus.B     = '0;
    bus.HiWE  = 1'b0;
    bus.LoWE  = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    checkOutput("rst_hi", 64'(bus.Hi), 64'h0);
    checkOutput("rst_lo", 64'(bus.Lo), 64'h0);
    checkOutput("rst_busy", 64'(bus.Busy), 64'h0);
    checkOutput("rst_done", 64'(bus.Done), 64'h0);
    @(negedge Clk);
    Reset = 1'b0;

    runOp("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT, MUL_BUSY);
    @(posedge Clk);
    #1;
    checkOutput("done_pulse", 64'(bus.Done), 64'h0);
    checkOutput("hold_hi", 64'(bus.Hi), 64'hFFFF_FFFE);

    runOp("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT, MUL_BUSY);
    runOp("mult_6m2", OP_MULT, 32'd6, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF4, MUL_LAT, MUL_BUSY);
    runOp("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT, DIV_BUSY);
    runOp("divu_z", OP_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, DIV_LAT, DIV_BUSY);
    runOp("div_z", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, DIV_LAT, DIV_BUSY);
    runOp("divu_16", OP_DIVU, 32'hFFFF_FFFF, 32'd16, 32'h0000_000F, 32'h0FFF_FFFF, DIV_LAT, DIV_BUSY);
    runOp("div_100_m7", OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, DIV_LAT, DIV_BUSY);

    // Overflow divide with a stray Start/MTHI mid-run and an MTHI/MTLO in the last busy cycle.
    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge Clk);
      #1;
      lat++;
      if (bus.Done) break;
      bus.Start = (lat == 5);
      bus.HiWE  = (lat == 5) || (lat == 33);
      bus.LoWE  = (lat == 33);
      bus.Op    = OP_MULTU;
      bus.A     = 32'h5555;
      bus.B     = 32'd3;
    end
    bus.Start = 1'b0;
    bus.HiWE  = 1'b0;
    bus.LoWE  = 1'b0;
    checkOutput("ovf_hi", 64'(bus.Hi), 64'h0);
    checkOutput("ovf_lo", 64'(bus.Lo), 64'h8000_0000);
    checkOutput("ovf_lat", 64'(lat), 64'd34);
    doneCnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk);
      #1;
      if (bus.Done) doneCnt++;
    end
    checkOutput("ovf_nostray", 64'(doneCnt), 64'h0);
    checkOutput("ovf_hold_lo", 64'(bus.Lo), 64'h8000_0000);

    applyStimulus(OP_MULT, 32'h0000_CAFE, 32'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("mt_both_hi", 64'(bus.Hi), 64'h0000_CAFE);
    checkOutput("mt_both_lo", 64'(bus.Lo), 64'h0000_CAFE);

    applyStimulus(OP_DIVU, 32'd100, 32'd7, 1'b1, 1'b0, 1'b1);
    checkOutput("start_wins_hold", 64'(bus.Hi), 64'h0000_CAFE);
    waitDone(lat, busyCnt);
    checkOutput("start_wins_hi", 64'(bus.Hi), 64'd2);
    checkOutput("start_wins_lo", 64'(bus.Lo), 64'd14);

    applyStimulus(OP_DIVU, 32'hFFFF_FFFF, 32'd3, 1'b0, 1'b0, 1'b1);
    repeat (10) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    checkOutput("abort_busy", 64'(bus.Busy), 64'h0);
    checkOutput("abort_hi", 64'(bus.Hi), 64'h0);
    checkOutput("abort_lo", 64'(bus.Lo), 64'h0);
    @(negedge Clk);
    Reset = 1'b0;
    doneCnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk);
      #1;
      if (bus.Done || bus.Busy) doneCnt++;
    end
    checkOutput("abort_quiet", 64'(doneCnt), 64'h0);

    applyStimulus(OP_MULT, 32'h0000_1234, 32'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("mthi_hi", 64'(bus.Hi), 64'h0000_1234);
    checkOutput("mthi_lo", 64'(bus.Lo), 64'h0);

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
